// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned N               = 3;
   localparam int unsigned ROB_SZ          = 32;
   localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);
   localparam int unsigned PHYS_REG_W      = 6;
   localparam int unsigned ARCH_REG_W      = 5;

   typedef struct packed {
      logic [31:0]           pc;
      logic [ARCH_REG_W-1:0] arch_reg;
      logic [PHYS_REG_W-1:0] t_new;
      logic [PHYS_REG_W-1:0] t_old;
      logic                  complete;
   } rob_packet_t;

   typedef logic [$clog2(ROB_SZ)-1:0] rob_idx_t;

endpackage

// File: rtl/reorder_buffer_ptr_adv.sv
// Circular pointer advance: sum_c = (ptr + inc) mod DEPTH, for inc <= DEPTH.
module reorder_buffer_ptr_adv #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = $clog2(DEPTH),
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic [IDX_W-1:0] ptr,
   input  logic [CNT_W-1:0] inc,
   output logic [IDX_W-1:0] sum_c
);

   localparam int unsigned SUM_W = CNT_W + 1;

   logic [SUM_W-1:0] raw_c;

   // Wide add, then a single conditional subtract folds back into range
   always_comb begin
      raw_c = SUM_W'(ptr) + SUM_W'(inc);
      if (raw_c >= SUM_W'(DEPTH)) begin
         raw_c = raw_c - SUM_W'(DEPTH);
      end
      sum_c = IDX_W'(raw_c);
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dispatch writes at the tail, retire drains
// at the head; up to N oldest entries are presented to retire every cycle.
// Optional macro ROB_TAIL_RESTORE_EN adds branch-mispredict tail restore.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH = ROB_SZ,
   localparam int unsigned IDX_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned NSB   = NUM_SCALAR_BITS
) (
   input  logic              clock,
   input  logic              reset,
   input  rob_packet_t       rob_inputs [N],
   input  logic [NSB-1:0]    rob_inputs_valid,
   output logic [NSB-1:0]    rob_spots,
   output logic [IDX_W-1:0]  rob_tail,
   output rob_packet_t       rob_outputs [N],
   output logic [NSB-1:0]    rob_outputs_valid,
`ifdef ROB_TAIL_RESTORE_EN
   input  logic              tail_restore_valid,
   input  logic [IDX_W-1:0]  tail_restore,
`endif
   input  logic [NSB-1:0]    num_retiring
);

   localparam int unsigned SUM_W = CNT_W + 1;

   rob_packet_t      entries_q [DEPTH];
   rob_packet_t      entries_d [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [NSB-1:0]   k_c;
   logic [NSB-1:0]   r_c;
   logic [CNT_W-1:0] free_c;
   logic [IDX_W-1:0] head_adv_c;
   logic [IDX_W-1:0] tail_adv_c;
   logic [IDX_W-1:0] out_idx_c [N];
   logic [IDX_W-1:0] in_idx_c  [N];

   // Per-slot read indices from head and write indices from tail
   for (genvar i = 0; i < N; i++) begin : g_slot
      reorder_buffer_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_out_idx (
         .ptr   (head_q),
         .inc   (CNT_W'(i)),
         .sum_c (out_idx_c[i])
      );
      reorder_buffer_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_in_idx (
         .ptr   (tail_q),
         .inc   (CNT_W'(i)),
         .sum_c (in_idx_c[i])
      );
   end

   reorder_buffer_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_head_adv (
      .ptr   (head_q),
      .inc   (CNT_W'(r_c)),
      .sum_c (head_adv_c)
   );

   reorder_buffer_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_tail_adv (
      .ptr   (tail_q),
      .inc   (CNT_W'(k_c)),
      .sum_c (tail_adv_c)
   );

   // Retire-facing and dispatch-facing views of registered state
   always_comb begin
      free_c            = CNT_W'(DEPTH) - count_q;
      rob_spots         = (free_c >= CNT_W'(N)) ? NSB'(N) : NSB'(free_c);
      rob_outputs_valid = (count_q >= CNT_W'(N)) ? NSB'(N) : NSB'(count_q);
      rob_tail          = tail_q;
      for (int i = 0; i < N; i++) begin
         rob_outputs[i] = (NSB'(i) < rob_outputs_valid) ? entries_q[out_idx_c[i]] : '0;
      end
   end

   // Accepted dispatch and retire counts, clamped to what the buffer allows
   always_comb begin
      k_c = (rob_inputs_valid < rob_spots) ? rob_inputs_valid : rob_spots;
      r_c = (num_retiring < rob_outputs_valid) ? num_retiring : rob_outputs_valid;
`ifdef ROB_TAIL_RESTORE_EN
      if (tail_restore_valid) begin
         k_c = '0;
      end
`endif
   end

`ifdef ROB_TAIL_RESTORE_EN
   logic [SUM_W-1:0] restore_cnt_c;

   // Occupancy after restore is the distance from the post-retire head
   always_comb begin
      restore_cnt_c = SUM_W'(tail_restore) + SUM_W'(DEPTH) - SUM_W'(head_adv_c);
      if (restore_cnt_c >= SUM_W'(DEPTH)) begin
         restore_cnt_c = restore_cnt_c - SUM_W'(DEPTH);
      end
   end
`endif

   // Next-state: write dispatched entries, advance pointers, update occupancy
   always_comb begin
      entries_d = entries_q;
      for (int j = 0; j < N; j++) begin
         if (NSB'(j) < k_c) begin
            entries_d[in_idx_c[j]] = rob_inputs[j];
         end
      end
      head_d  = head_adv_c;
      tail_d  = tail_adv_c;
      count_d = count_q + CNT_W'(k_c) - CNT_W'(r_c);
`ifdef ROB_TAIL_RESTORE_EN
      if (tail_restore_valid) begin
         tail_d  = tail_restore;
         count_d = CNT_W'(restore_cnt_c);
      end
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=8, N=3) with a queue scoreboard.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned NSB   = NUM_SCALAR_BITS;

   logic              clock = 1'b0;
   logic              reset;
   rob_packet_t       rob_inputs [N];
   logic [NSB-1:0]    rob_inputs_valid;
   logic [NSB-1:0]    rob_spots;
   logic [IDX_W-1:0]  rob_tail;
   rob_packet_t       rob_outputs [N];
   logic [NSB-1:0]    rob_outputs_valid;
   logic [NSB-1:0]    num_retiring;
`ifdef ROB_TAIL_RESTORE_EN
   logic              tail_restore_valid;
   logic [IDX_W-1:0]  tail_restore;
`endif

   reorder_buffer #(.DEPTH(DEPTH)) dut (
      .clock             (clock),
      .reset             (reset),
      .rob_inputs        (rob_inputs),
      .rob_inputs_valid  (rob_inputs_valid),
      .rob_spots         (rob_spots),
      .rob_tail          (rob_tail),
      .rob_outputs       (rob_outputs),
      .rob_outputs_valid (rob_outputs_valid),
`ifdef ROB_TAIL_RESTORE_EN
      .tail_restore_valid(tail_restore_valid),
      .tail_restore      (tail_restore),
`endif
      .num_retiring      (num_retiring)
   );

   always #5 clock = ~clock;

   rob_packet_t sb [$];
   int          m_tail;
   int          n_run;
   int          n_fail;

   function automatic int minf(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic rob_packet_t exp_slot(int i);
      if (i < minf(sb.size(), N)) return sb[i];
      return '0;
   endfunction

   // Load input slots with packets whose t_new runs from tbase upward
   task automatic load_inputs(input int nv, input int tbase);
      for (int j = 0; j < N; j++) begin
         rob_inputs[j].pc       = $urandom;
         rob_inputs[j].arch_reg = 5'(j + 1);
         rob_inputs[j].t_new    = 6'(tbase + j);
         rob_inputs[j].t_old    = 6'(tbase + j + 20);
         rob_inputs[j].complete = 1'b1;
      end
      rob_inputs_valid = NSB'(nv);
   endtask

   // Drive one cycle of dispatch/retire and advance the scoreboard
   task automatic drive(input int nv, input int tbase, input int nret);
      int sz, k, r;
      load_inputs(nv, tbase);
      num_retiring = NSB'(nret);
      sz = sb.size();
      k  = minf(nv, minf(DEPTH - sz, N));
      r  = minf(nret, minf(sz, N));
      @(posedge clock);
      #1;
      repeat (r) void'(sb.pop_front());
      for (int j = 0; j < k; j++) sb.push_back(rob_inputs[j]);
      m_tail = (m_tail + k) % DEPTH;
      rob_inputs_valid = '0;
      num_retiring     = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      load_inputs(3, 1);
      num_retiring = NSB'(2);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      rob_inputs_valid = '0;
      num_retiring     = '0;
      sb.delete();
      m_tail = 0;
      n_run++;
      if (rob_outputs_valid !== NSB'(0)) begin
         n_fail++; $display("FAIL reset_valid got %0d exp 0", rob_outputs_valid);
      end
      n_run++;
      if (rob_spots !== NSB'(3)) begin
         n_fail++; $display("FAIL reset_spots got %0d exp 3", rob_spots);
      end
      n_run++;
      if (rob_tail !== IDX_W'(0)) begin
         n_fail++; $display("FAIL reset_tail got %0d exp 0", rob_tail);
      end
      for (int i = 0; i < N; i++) begin
         n_run++;
         if (rob_outputs[i] !== rob_packet_t'(0)) begin
            n_fail++; $display("FAIL reset_slot%0d got %h exp 0", i, rob_outputs[i]);
         end
      end
   endtask

   task automatic test_dispatch;
      drive(3, 5, 0);
      n_run++;
      if (rob_outputs_valid !== NSB'(3)) begin
         n_fail++; $display("FAIL disp_valid got %0d exp 3", rob_outputs_valid);
      end
      n_run++;
      if (rob_tail !== IDX_W'(3)) begin
         n_fail++; $display("FAIL disp_tail got %0d exp 3", rob_tail);
      end
      for (int i = 0; i < N; i++) begin
         n_run++;
         if (rob_outputs[i] !== exp_slot(i) || rob_outputs[i].t_new !== 6'(5 + i)) begin
            n_fail++; $display("FAIL disp_slot%0d got t_new %0d exp %0d", i, rob_outputs[i].t_new, 5 + i);
         end
      end
   endtask

   task automatic test_fill_full;
      drive(3, 8, 0);
      drive(2, 11, 0);
      n_run++;
      if (rob_spots !== NSB'(0)) begin
         n_fail++; $display("FAIL full_spots got %0d exp 0", rob_spots);
      end
      drive(2, 30, 0);
      n_run++;
      if (sb.size() != DEPTH || rob_spots !== NSB'(0) || rob_outputs_valid !== NSB'(3)) begin
         n_fail++; $display("FAIL full_drop got spots %0d valid %0d exp 0 3", rob_spots, rob_outputs_valid);
      end
      n_run++;
      if (rob_tail !== IDX_W'(0)) begin
         n_fail++; $display("FAIL full_tail got %0d exp 0", rob_tail);
      end
      n_run++;
      if (rob_outputs[0].t_new !== 6'(5)) begin
         n_fail++; $display("FAIL full_head got t_new %0d exp 5", rob_outputs[0].t_new);
      end
   endtask

   task automatic test_full_retire;
      drive(3, 40, 2);
      n_run++;
      if (rob_spots !== NSB'(2)) begin
         n_fail++; $display("FAIL fullret_spots got %0d exp 2", rob_spots);
      end
      n_run++;
      if (rob_tail !== IDX_W'(0)) begin
         n_fail++; $display("FAIL fullret_tail got %0d exp 0", rob_tail);
      end
      for (int i = 0; i < N; i++) begin
         n_run++;
         if (rob_outputs[i] !== exp_slot(i) || rob_outputs[i].t_new !== 6'(7 + i)) begin
            n_fail++; $display("FAIL fullret_slot%0d got t_new %0d exp %0d", i, rob_outputs[i].t_new, 7 + i);
         end
      end
   endtask

   task automatic test_wrap;
      logic [5:0] wexp [N];
      wexp[0] = 6'd11; wexp[1] = 6'd12; wexp[2] = 6'd50;
      drive(0, 0, 3);
      drive(0, 0, 1);
      drive(2, 50, 0);
      for (int i = 0; i < N; i++) begin
         n_run++;
         if (rob_outputs[i] !== exp_slot(i) || rob_outputs[i].t_new !== wexp[i]) begin
            n_fail++; $display("FAIL wrap_slot%0d got t_new %0d exp %0d", i, rob_outputs[i].t_new, wexp[i]);
         end
      end
      n_run++;
      if (rob_tail !== IDX_W'(2)) begin
         n_fail++; $display("FAIL wrap_tail got %0d exp 2", rob_tail);
      end
      drive(0, 0, 3);
      n_run++;
      if (rob_outputs_valid !== NSB'(1) || rob_outputs[0].t_new !== 6'd51) begin
         n_fail++; $display("FAIL wrap_retire got valid %0d t_new %0d exp 1 51", rob_outputs_valid, rob_outputs[0].t_new);
      end
   endtask

   task automatic test_over_retire;
      drive(0, 0, 3);
      n_run++;
      if (rob_outputs_valid !== NSB'(0) || rob_spots !== NSB'(3)) begin
         n_fail++; $display("FAIL overret_empty got valid %0d spots %0d exp 0 3", rob_outputs_valid, rob_spots);
      end
      drive(0, 0, 3);
      drive(2, 60, 0);
      n_run++;
      if (rob_outputs_valid !== NSB'(2) || rob_outputs[0].t_new !== 6'd60 || rob_outputs[1].t_new !== 6'd61) begin
         n_fail++; $display("FAIL overret_head got valid %0d t_new %0d exp 2 60", rob_outputs_valid, rob_outputs[0].t_new);
      end
      n_run++;
      if (rob_tail !== IDX_W'(4)) begin
         n_fail++; $display("FAIL overret_tail got %0d exp 4", rob_tail);
      end
   endtask

`ifdef ROB_TAIL_RESTORE_EN
   task automatic test_restore;
      drive(3, 62, 0);
      load_inputs(3, 33);
      num_retiring       = NSB'(1);
      tail_restore_valid = 1'b1;
      tail_restore       = IDX_W'(4);
      @(posedge clock);
      #1;
      tail_restore_valid = 1'b0;
      rob_inputs_valid   = '0;
      num_retiring       = '0;
      void'(sb.pop_front());
      while (sb.size() > 1) void'(sb.pop_back());
      m_tail = 4;
      n_run++;
      if (rob_tail !== IDX_W'(4) || rob_outputs_valid !== NSB'(1)) begin
         n_fail++; $display("FAIL restore got tail %0d valid %0d exp 4 1", rob_tail, rob_outputs_valid);
      end
      n_run++;
      if (rob_outputs[0] !== exp_slot(0) || rob_outputs[0].t_new !== 6'd61) begin
         n_fail++; $display("FAIL restore_head got t_new %0d exp 61", rob_outputs[0].t_new);
      end
   endtask
`endif

   task automatic test_back_to_back;
      rob_packet_t ep;
      for (int c = 0; c < 300; c++) begin
         if (c == 150) begin
            test_reset();
         end
         drive($urandom_range(0, 3), $urandom_range(0, 60), $urandom_range(0, 3));
         n_run++;
         if (rob_outputs_valid !== NSB'(minf(sb.size(), N))) begin
            n_fail++; $display("FAIL b2b_valid c%0d got %0d exp %0d", c, rob_outputs_valid, minf(sb.size(), N));
         end
         n_run++;
         if (rob_spots !== NSB'(minf(DEPTH - sb.size(), N))) begin
            n_fail++; $display("FAIL b2b_spots c%0d got %0d exp %0d", c, rob_spots, minf(DEPTH - sb.size(), N));
         end
         n_run++;
         if (rob_tail !== IDX_W'(m_tail)) begin
            n_fail++; $display("FAIL b2b_tail c%0d got %0d exp %0d", c, rob_tail, m_tail);
         end
         for (int i = 0; i < N; i++) begin
            ep = exp_slot(i);
            n_run++;
            if (rob_outputs[i] !== ep) begin
               n_fail++; $display("FAIL b2b_slot%0d c%0d got %h exp %h", i, c, rob_outputs[i], ep);
            end
         end
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      m_tail = 0;
      rob_inputs_valid = '0;
      num_retiring     = '0;
      for (int j = 0; j < N; j++) rob_inputs[j] = '0;
`ifdef ROB_TAIL_RESTORE_EN
      tail_restore_valid = 1'b0;
      tail_restore       = '0;
`endif
      test_reset();
      test_dispatch();
      test_fill_full();
      test_full_retire();
      test_wrap();
      test_over_retire();
`ifdef ROB_TAIL_RESTORE_EN
      test_restore();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order buffer of ROB_PACKETs, written at the tail by dispatch and drained at the head by retire. Presents up to `N oldest entries to the retire stage each cycle and accepts the retire count back. Supplies rob_outputs/rob_outputs_valid and consumes num_retiring on the retire interface. Reports free spots to dispatch.

Parameters:
DEPTH, `ROB_SZ (32), number of entries; integer, DEPTH >= `N; not required to be a power of two.
IDX_W, $clog2(DEPTH), head/tail pointer width.
CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
clock  in  1  system clock, posedge
reset  in  1  synchronous, active-high
rob_inputs  in  ROB_PACKET[`N]  dispatched packets; slot 0 oldest
rob_inputs_valid  in  `NUM_SCALAR_BITS  count of valid rob_inputs, prefix-packed
rob_spots  out  `NUM_SCALAR_BITS  entries dispatch may write this cycle
rob_tail  out  IDX_W  current tail index, tagged onto dispatched instructions
rob_outputs  out  ROB_PACKET[`N]  head..head+`N-1; slot 0 oldest
rob_outputs_valid  out  `NUM_SCALAR_BITS  count of valid rob_outputs
num_retiring  in  `NUM_SCALAR_BITS  entries retired this cycle, from retire stage

Behaviour:
- State: entries[DEPTH], head, tail (IDX_W), count (CNT_W).
- Reset: head=0, tail=0, count=0, all entries zeroed. rob_outputs_valid=0, rob_outputs all zero, rob_spots=min(DEPTH,`N), rob_tail=0.
- Outputs are combinational from registered state; zero latency.
  - rob_outputs[i] = entries[(head+i) mod DEPTH] for i < rob_outputs_valid, else zero.
  - rob_outputs_valid = min(count, `N).
  - rob_spots = min(DEPTH-count, `N). Uses registered count; same-cycle retires never create spots.
- Dispatch commit at posedge:
  - k = min(rob_inputs_valid, rob_spots).
  - entries[(tail+j) mod DEPTH] <= rob_inputs[j] for j<k.
  - tail <= (tail+k) mod DEPTH.
  - Inputs beyond k are dropped silently.
- Retire commit at posedge:
  - r = min(num_retiring, rob_outputs_valid).
  - head <= (head+r) mod DEPTH.
  - Retired entries need not be cleared.
- Simultaneous dispatch and retire: count <= count + k - r.
  - Never exceeds DEPTH because k <= DEPTH-count.
  - Never goes negative because r <= count.
- Wrap-around: every index arithmetic is explicitly modulo DEPTH, using CNT_W+1-bit intermediates.
- Full (count==DEPTH): rob_spots=0; retire still proceeds.
- Empty (count==0): rob_outputs_valid=0; num_retiring is ignored.
- Full/empty are distinguished by count only, never by head==tail.
- Reset mid-operation: all state returns to reset values on the next edge; dispatch and retire in that cycle are ignored.

Optional Feature:
Macro ROB_TAIL_RESTORE_EN, branch-mispredict recovery.
- Defined:
  - Adds input tail_restore_valid (1) and input tail_restore (IDX_W).
  - When tail_restore_valid is high:
    - tail <= tail_restore.
    - Dispatch that cycle is ignored (k=0).
    - Retire still applies.
    - count <= ((tail_restore - head_next) mod DEPTH), where head_next is the post-retire head.
    - If tail_restore == head_next, count = 0. A restore can only squash, never make the ROB full.
- Undefined: ports absent; tail only advances by dispatch.

Decomposition:
- sys_defs.svh: ROB_PACKET (T_new, T_old, etc.), `ROB_SZ, `N, `NUM_SCALAR_BITS, and typedef ROB_IDX = logic[$clog2(`ROB_SZ)-1:0].
- One natural sub-module, rob_ptr_adv: computes (ptr + inc) mod DEPTH. Instantiated for head, tail, and each output/input slot index.

Test Plan:
- Reset, then idle (N=3, DEPTH=8) -> rob_outputs_valid=0, rob_spots=3, rob_tail=0, rob_outputs zero.
- Dispatch 3, T_new=5,6,7, one cycle -> next cycle rob_outputs_valid=3, rob_outputs[0..2].T_new=5,6,7, rob_tail=3.
- Fill to 8 with no retire -> rob_spots=0. Dispatch 2 more -> dropped, count stays 8, rob_tail=0.
- Full ROB: dispatch 3 and num_retiring=2 in the same cycle -> k=0, head=2, count=6. Next cycle rob_spots=2.
- Wrap-around: head=6, count=4 -> rob_outputs map to indices 6,7,0 in slot order. Retire 3 -> head=1, count=1.
- num_retiring=3 while rob_outputs_valid=1 -> only 1 retired, count=0, head advances by 1.
- With ROB_TAIL_RESTORE_EN: head=2, tail=7, restore to 4 with num_retiring=1 -> tail=4, head=3, count=1.
